// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial WIDTH-bit subtractor, diff = a - b, LSB first.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int                 c_CNT_W = $clog2(WIDTH + 1);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
   localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_a_sr;
   logic [WIDTH-1:0]   r_b_sr;
   logic               r_bin;
   logic [c_CNT_W-1:0] r_count;

   logic               w_x;
   logic               w_y;
   logic               w_d;
   logic               w_bout;
   logic [WIDTH-1:0]   w_diff_next;

   // Single full-subtractor cell; the borrow flop closes the chain across cycles.
   assign w_x    = r_a_sr[0];
   assign w_y    = r_b_sr[0];
   assign w_d    = w_x ^ w_y ^ r_bin;
   assign w_bout = (~w_x & w_y) | (~(w_x ^ w_y) & r_bin);

   generate
      if (WIDTH == 1) begin : g_diff_single
         assign w_diff_next = w_d;
      end else begin : g_diff_shift
         assign w_diff_next = {w_d, diff[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         diff    <= '0;
         borrow  <= 1'b0;
         r_count <= '0;
         r_a_sr  <= '0;
         r_b_sr  <= '0;
         r_bin   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  r_a_sr  <= a;
                  r_b_sr  <= b;
                  r_bin   <= 1'b0;
                  r_count <= '0;
                  busy    <= 1'b1;
                  r_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               diff    <= w_diff_next;
               r_a_sr  <= r_a_sr >> 1;
               r_b_sr  <= r_b_sr >> 1;
               r_bin   <= w_bout;
               r_count <= r_count + c_ONE;
               if (r_count == c_LAST) begin
                  borrow  <= w_bout;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               done    <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       s8, busy8, done8, bo8;
   logic [7:0] a8, b8, d8;
   logic       s1, busy1, done1, bo1;
   logic [0:0] a1, b1, d1;

   int checks   = 0;
   int failures = 0;

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .diff(d8), .borrow(bo8)
   );

   serial_subtractor #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .diff(d1), .borrow(bo1)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] diff;
      logic       borrow;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Issue one op on the 8-bit unit; returns at the negedge where done is seen.
   task automatic run8(input logic [7:0] ia, input logic [7:0] ib,
                       output logic [7:0] od, output logic ob,
                       output int lat, output int busy_cnt, output bit ok);
      @(negedge clk);
      s8 = 1'b1; a8 = ia; b8 = ib;
      @(negedge clk);
      s8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom);
      lat = 1; busy_cnt = 0; ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done8) begin
            ok = 1'b1;
            break;
         end
         if (busy8) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      od = d8;
      ob = bo8;
   endtask

   task automatic run1(input logic ia, input logic ib,
                       output logic od, output logic ob, output int lat, output bit ok);
      @(negedge clk);
      s1 = 1'b1; a1 = ia; b1 = ib;
      @(negedge clk);
      s1 = 1'b0;
      a1 = ~a1; b1 = ~b1;
      lat = 1; ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (done1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
         lat++;
      end
      od = d1;
      ob = bo1;
   endtask

   initial begin
      logic [7:0] od, hold_d, ra, rb, exp_d;
      logic       ob, od1, ob1;
      int         lat, bc, nd, first_t, second_t;
      bit         ok;

      vecs[0] = '{8'd13,  8'd5,   8'd8,   1'b0};
      vecs[1] = '{8'd5,   8'd13,  8'd248, 1'b1};
      vecs[2] = '{8'd0,   8'd1,   8'd255, 1'b1};
      vecs[3] = '{8'hAA,  8'hAA,  8'd0,   1'b0};
      vecs[4] = '{8'd255, 8'd0,   8'd255, 1'b0};
      vecs[5] = '{8'd0,   8'd255, 8'd1,   1'b1};
      vecs[6] = '{8'd128, 8'd127, 8'd1,   1'b0};
      vecs[7] = '{8'd127, 8'd128, 8'd255, 1'b1};

      rst = 1'b1; s8 = 1'b0; s1 = 1'b0;
      a8 = 8'd0; b8 = 8'd0; a1 = 1'b0; b1 = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_busy8",   {31'd0, busy8}, 32'd0);
      chk("reset_done8",   {31'd0, done8}, 32'd0);
      chk("reset_diff8",   {24'd0, d8},    32'd0);
      chk("reset_borrow8", {31'd0, bo8},   32'd0);
      chk("reset_busy1",   {31'd0, busy1}, 32'd0);
      chk("reset_diff1",   {31'd0, d1},    32'd0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run8(vecs[i].a, vecs[i].b, od, ob, lat, bc, ok);
         chk("vec_done_seen", {31'd0, ok}, 32'd1);
         chk("vec_diff",      {24'd0, od}, {24'd0, vecs[i].diff});
         chk("vec_borrow",    {31'd0, ob}, {31'd0, vecs[i].borrow});
         chk("vec_latency",   lat, 32'd9);
         chk("vec_busy_cycles", bc, 32'd8);
         hold_d = od;
         @(negedge clk);
         chk("vec_done_pulse", {31'd0, done8}, 32'd0);
         repeat (2) @(negedge clk);
         chk("vec_diff_hold", {24'd0, d8}, {24'd0, hold_d});
      end

      // Second start mid-SHIFT must be ignored, operands changed after acceptance.
      @(negedge clk);
      s8 = 1'b1; a8 = 8'd200; b8 = 8'd100;
      @(negedge clk);
      s8 = 1'b0; a8 = 8'd1; b8 = 8'd2;
      repeat (2) @(negedge clk);
      s8 = 1'b1;
      @(negedge clk);
      s8 = 1'b0;
      nd = 0; od = 8'd0; ob = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (done8) begin
            nd++;
            od = d8;
            ob = bo8;
         end
         @(negedge clk);
      end
      chk("restart_done_count", nd, 32'd1);
      chk("restart_diff",   {24'd0, od}, 32'd100);
      chk("restart_borrow", {31'd0, ob}, 32'd0);

      // Reset three cycles into SHIFT aborts without a done pulse.
      @(negedge clk);
      s8 = 1'b1; a8 = 8'd50; b8 = 8'd20;
      @(negedge clk);
      s8 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy",   {31'd0, busy8}, 32'd0);
      chk("abort_done",   {31'd0, done8}, 32'd0);
      chk("abort_diff",   {24'd0, d8},    32'd0);
      chk("abort_borrow", {31'd0, bo8},   32'd0);
      rst = 1'b0;
      nd = 0;
      for (int i = 0; i < 12; i++) begin
         if (done8) nd++;
         @(negedge clk);
      end
      chk("abort_no_done", nd, 32'd0);
      run8(8'd77, 8'd33, od, ob, lat, bc, ok);
      chk("post_abort_done_seen", {31'd0, ok}, 32'd1);
      chk("post_abort_diff",   {24'd0, od}, 32'd44);
      chk("post_abort_borrow", {31'd0, ob}, 32'd0);

      // Start held high: accepted every WIDTH+2 cycles.
      @(negedge clk);
      s8 = 1'b1; a8 = 8'd9; b8 = 8'd4;
      first_t = -1; second_t = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done8) begin
            if (first_t < 0) first_t = i;
            else if (second_t < 0) second_t = i;
            chk("b2b_diff", {24'd0, d8}, 32'd5);
         end
      end
      s8 = 1'b0;
      chk("b2b_spacing", second_t - first_t, 32'd10);
      repeat (12) @(negedge clk);

      for (int n = 0; n < 1000; n++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         exp_d = ra - rb;
         run8(ra, rb, od, ob, lat, bc, ok);
         chk("rand_done_seen", {31'd0, ok}, 32'd1);
         chk("rand_diff",   {24'd0, od}, {24'd0, exp_d});
         chk("rand_borrow", {31'd0, ob}, {31'd0, (ra < rb)});
      end

      for (int k = 0; k < 4; k++) begin
         logic ia, ib, ed;
         ia = k[1];
         ib = k[0];
         ed = ia - ib;
         run1(ia, ib, od1, ob1, lat, ok);
         chk("w1_done_seen", {31'd0, ok}, 32'd1);
         chk("w1_diff",    {31'd0, od1}, {31'd0, ed});
         chk("w1_borrow",  {31'd0, ob1}, {31'd0, (ia < ib)});
         chk("w1_latency", lat, 32'd2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
